// File: rtl/uart_fifo_if.sv
// Handshake and status bundle between a UART FIFO and its producer/consumer.
// Error ports (ovf, udf, err_clr) exist only when UART_FIFO_ERR_EN is defined.
interface uart_fifo_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
);

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          flush;
  logic          trig_mode;
  logic [AW:0]   trig_lvl;
  logic          trig_irq;
`ifdef UART_FIFO_ERR_EN
  logic          ovf;
  logic          udf;
  logic          err_clr;
`endif

  // Producer/consumer side: drives requests and configuration, observes status.
  modport master (
    output wr_en, wr_data, rd_en, flush, trig_mode, trig_lvl,
`ifdef UART_FIFO_ERR_EN
    output err_clr, input ovf, udf,
`endif
    input  rd_data, full, empty, count, trig_irq
  );

  // FIFO side.
  modport slave (
    input  wr_en, wr_data, rd_en, flush, trig_mode, trig_lvl,
`ifdef UART_FIFO_ERR_EN
    input  err_clr, output ovf, udf,
`endif
    output rd_data, full, empty, count, trig_irq
  );

endinterface

// File: rtl/uart_fifo_param.sv
// Parameterised show-ahead synchronous FIFO for UART TX/RX paths with exact count,
// flush and trigger-level interrupt. Sticky ovf/udf flags built only with UART_FIFO_ERR_EN.
module uart_fifo_param #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  uart_fifo_if.slave       bus
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          trig_irq_q;

  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_d;
  logic [CW-1:0] count_d;

  logic          full_c;
  logic          empty_c;
  logic          wr_acc_c;
  logic          rd_acc_c;
  logic          mem_we_c;
  logic          trig_c;

  // Status is decoded from the count register, never from pointer equality.
  assign full_c  = (count_q == FULL_CNT);
  assign empty_c = (count_q == '0);

  // A write on a full FIFO is still accepted when a read frees the head slot.
  assign wr_acc_c = bus.wr_en & (~full_c | bus.rd_en);
  assign rd_acc_c = bus.rd_en & ~empty_c;
  assign mem_we_c = wr_acc_c & ~bus.flush;

  // Next-state for pointers and occupancy; flush overrides any request.
  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr_d = wr_ptr + AW'(1);
      end
      if (rd_acc_c) begin
        rd_ptr_d = rd_ptr + AW'(1);
      end
      unique case ({wr_acc_c, rd_acc_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr_d;
      rd_ptr  <= rd_ptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // TX sense asks for refill at or below the level; RX sense asks for drain at or above it.
  always_comb begin
    trig_c = 1'b0;
    if (bus.trig_mode) begin
      trig_c = (count_q >= bus.trig_lvl) && !empty_c;
    end else begin
      trig_c = (count_q <= bus.trig_lvl);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_irq_q <= 1'b0;
    end else begin
      trig_irq_q <= trig_c;
    end
  end

`ifdef UART_FIFO_ERR_EN
  logic ovf_q;
  logic udf_q;
  logic ovf_set_c;
  logic udf_set_c;

  // Any read on empty is an underflow, even when a same-cycle write lands.
  assign ovf_set_c = ~bus.flush & bus.wr_en & full_c & ~bus.rd_en;
  assign udf_set_c = ~bus.flush & bus.rd_en & empty_c;

  // Sticky flags; a new error in the clearing cycle wins over err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set_c) begin
        ovf_q <= 1'b1;
      end else if (bus.err_clr) begin
        ovf_q <= 1'b0;
      end
      if (udf_set_c) begin
        udf_q <= 1'b1;
      end else if (bus.err_clr) begin
        udf_q <= 1'b0;
      end
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`endif

  assign bus.rd_data  = mem[rd_ptr];
  assign bus.full     = full_c;
  assign bus.empty    = empty_c;
  assign bus.count    = count_q;
  assign bus.trig_irq = trig_irq_q;

endmodule
